cci_mpf_shim_lockstep_issue: RTL and testbench
==============================================

// Module: cci_mpf_shim_lockstep_issue
//
// PURPOSE
//  Issue stage immediately downstream of the lockstep c0/c1 Tx buffer.
//  Inspects the buffer head and drives its single dequeue (deq_tx) so both
//  channels leave in lockstep. Forwards the pair to the FIU through one
//  register stage, honouring per-channel almost-full. Keeps multi-beat
//  c1 writes contiguous and counts back-pressure stall cycles.
//
// PARAMETERS
//  C0_TX_BITS   100  width of packed c0 request payload (header incl.)
//  C1_TX_BITS   600  width of packed c1 request payload (header+data)
//  STAT_BITS    16   width of saturating stall counters
//
// PORTS
//  clk            in   1           clock
//  reset          in   1           async, active-high reset
//  head_not_empty in   1           buffer head holds an entry
//  head_c0_valid  in   1           head c0 slot valid
//  head_c0_data   in   C0_TX_BITS  head c0 payload
//  head_c1_valid  in   1           head c1 slot valid
//  head_c1_is_wr  in   1           head c1 is a write request
//  head_c1_sop    in   1           head c1 is first beat of a packet
//  head_c1_len    in   2           head c1 cl_len (beats-1), valid at SOP
//  head_c1_data   in   C1_TX_BITS  head c1 payload
//  deq_tx         out  1           dequeue buffer head (combinational)
//  fiu_c0_almfull in   1           FIU c0 almost full
//  fiu_c1_almfull in   1           FIU c1 almost full
//  fiu_c0_valid   out  1           registered c0 request valid
//  fiu_c0_data    out  C0_TX_BITS  registered c0 payload
//  fiu_c1_valid   out  1           registered c1 request valid
//  fiu_c1_data    out  C1_TX_BITS  registered c1 payload
//  stats_clr      in   1           sync clear of stall counters
//  stall_c0       out  STAT_BITS   cycles head stalled on c0 almfull
//  stall_c1       out  STAT_BITS   cycles head stalled on c1 almfull
//  err_pkt        out  1           sticky multi-beat framing error
//
// BEHAVIOUR
//  - Reset (async): fiu_c0_valid=fiu_c1_valid=0, state=IDLE, beats_left=0,
//    stall_c0=stall_c1=0, err_pkt=0. Data regs don't-care. deq_tx=0
//    while reset asserted.
//  - in_pkt = (state==WR_PKT).
//  - ok0 = !head_c0_valid || !fiu_c0_almfull.
//  - ok1 = !head_c1_valid || !fiu_c1_almfull || in_pkt.
//    Beats after SOP ignore c1 almfull; the FIU almfull slack covers them.
//  - deq_tx = head_not_empty && ok0 && ok1. Entry never split: if either
//    channel is blocked, both stall.
//  - Latency 1: on deq_tx, fiu_cX_valid<=head_cX_valid, fiu_cX_data<=
//    head_cX_data next cycle; otherwise fiu_cX_valid<=0 (data holds).
//  - FSM (advances only on deq_tx with head_c1_valid && head_c1_is_wr):
//    IDLE: sop && len!=0 -> WR_PKT, beats_left<=len. sop && len==0 -> stay.
//          !sop -> err_pkt<=1, stay IDLE.
//    WR_PKT: !sop -> beats_left-1; ->IDLE when beats_left==1.
//            sop -> err_pkt<=1, restart: beats_left<=len (IDLE if len==0).
//    c1 non-write or c1 invalid: FSM unchanged.
//  - Stall counters, each cycle not in reset:
//    stall_c0 += (head_not_empty && head_c0_valid && fiu_c0_almfull);
//    stall_c1 += (head_not_empty && head_c1_valid && fiu_c1_almfull
//                 && !in_pkt).
//    Both channels blocked in one cycle -> both counters increment.
//    Counters saturate at all-ones. stats_clr wins over increment.
//  - err_pkt cleared only by reset.
//  - Reset mid-packet discards WR_PKT state. The buffer is reset by the
//    same signal, so no orphan beats remain.
//
// TESTING
//  1) Head c0 rd+c1 wr len0, no almfull -> deq_tx same cycle; both fiu
//     valids 1 cycle later, data equal to head.
//  2) c0_almfull=1 for 5 cycles with c0+c1 valid at head -> deq_tx=0,
//     no fiu valid, stall_c0=5, stall_c1=0. Release -> one issue.
//  3) 4-beat write (sop len=3), c1_almfull rises after beat 1 -> beats 2-4
//     issue back-to-back; stall_c1 unchanged; FSM back to IDLE; err_pkt=0.
//  4) Head c1 SOP arrives with beats_left=2 -> err_pkt=1 sticky; FSM
//     reloads from new len.
//  5) Force stall_c1 to 0xFFFE, hold c1 almfull 3 cycles -> 0xFFFF
//     saturates. stats_clr pulse -> 0.
//  6) Assert reset mid WR_PKT with fiu valids high -> all outputs 0
//     immediately (async). After release, next SOP is accepted cleanly.

Source files
------------

// File: rtl/cci_mpf_shim_lockstep_issue.sv
// Lockstep c0/c1 issue stage: dequeues the Tx buffer head as one unit, forwards
// both channels through one register stage, frames multi-beat writes and counts stalls.
module cci_mpf_shim_lockstep_issue #(
  parameter int C0_TX_BITS = 100,
  parameter int C1_TX_BITS = 600,
  parameter int STAT_BITS  = 16
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  head_not_empty,
  input  logic                  head_c0_valid,
  input  logic [C0_TX_BITS-1:0] head_c0_data,
  input  logic                  head_c1_valid,
  input  logic                  head_c1_is_wr,
  input  logic                  head_c1_sop,
  input  logic [1:0]            head_c1_len,
  input  logic [C1_TX_BITS-1:0] head_c1_data,
  output logic                  deq_tx,

  input  logic                  fiu_c0_almfull,
  input  logic                  fiu_c1_almfull,
  output logic                  fiu_c0_valid,
  output logic [C0_TX_BITS-1:0] fiu_c0_data,
  output logic                  fiu_c1_valid,
  output logic [C1_TX_BITS-1:0] fiu_c1_data,

  input  logic                  stats_clr,
  output logic [STAT_BITS-1:0]  stall_c0,
  output logic [STAT_BITS-1:0]  stall_c1,
  output logic                  err_pkt
);

  typedef enum logic {
    IDLE   = 1'b0,
    WR_PKT = 1'b1
  } state_t;

  localparam logic [STAT_BITS-1:0] STAT_ONE = {{(STAT_BITS-1){1'b0}}, 1'b1};
  localparam logic [STAT_BITS-1:0] STAT_MAX = {STAT_BITS{1'b1}};

  state_t                 state_q, state_d;
  logic [1:0]             beats_left_q, beats_left_d;
  logic                   err_pkt_q, err_pkt_d;
  logic [STAT_BITS-1:0]   stall_c0_q, stall_c0_d;
  logic [STAT_BITS-1:0]   stall_c1_q, stall_c1_d;
  logic                   fiu_c0_valid_q, fiu_c0_valid_d;
  logic                   fiu_c1_valid_q, fiu_c1_valid_d;
  logic [C0_TX_BITS-1:0]  fiu_c0_data_q;
  logic [C1_TX_BITS-1:0]  fiu_c1_data_q;

  logic                   in_pkt;
  logic                   ok0;
  logic                   ok1;
  logic                   deq;
  logic                   c1_wr_deq;
  logic                   c0_blocked;
  logic                   c1_blocked;

  // Continuation beats bypass c1 almfull so a packet is never split on the
  // FIU side; the FIU's almfull slack absorbs the remaining beats.
  assign in_pkt     = (state_q == WR_PKT);
  assign ok0        = !head_c0_valid || !fiu_c0_almfull;
  assign ok1        = !head_c1_valid || !fiu_c1_almfull || in_pkt;
  assign deq        = !reset && head_not_empty && ok0 && ok1;
  assign c1_wr_deq  = deq && head_c1_valid && head_c1_is_wr;

  assign c0_blocked = head_not_empty && head_c0_valid && fiu_c0_almfull;
  assign c1_blocked = head_not_empty && head_c1_valid && fiu_c1_almfull && !in_pkt;

  function automatic logic [STAT_BITS-1:0] stall_next(
    input logic [STAT_BITS-1:0] cur,
    input logic                 hit,
    input logic                 clr
  );
    logic [STAT_BITS-1:0] nxt;
    nxt = cur;
    if (clr) begin
      nxt = '0;
    end else if (hit && (cur != STAT_MAX)) begin
      nxt = cur + STAT_ONE;
    end
    return nxt;
  endfunction

  always_comb begin
    state_d      = state_q;
    beats_left_d = beats_left_q;
    err_pkt_d    = err_pkt_q;
    if (c1_wr_deq) begin
      case (state_q)
        IDLE: begin
          if (head_c1_sop) begin
            if (head_c1_len != 2'd0) begin
              state_d      = WR_PKT;
              beats_left_d = head_c1_len;
            end
          end else begin
            err_pkt_d = 1'b1;
          end
        end
        WR_PKT: begin
          if (head_c1_sop) begin
            // Unexpected SOP: flag it and resynchronise on the new packet.
            err_pkt_d    = 1'b1;
            beats_left_d = head_c1_len;
            state_d      = (head_c1_len != 2'd0) ? WR_PKT : IDLE;
          end else begin
            beats_left_d = beats_left_q - 2'd1;
            if (beats_left_q == 2'd1) begin
              state_d = IDLE;
            end
          end
        end
        default: begin
          state_d      = IDLE;
          beats_left_d = 2'd0;
        end
      endcase
    end
  end

  always_comb begin
    fiu_c0_valid_d = deq && head_c0_valid;
    fiu_c1_valid_d = deq && head_c1_valid;
    stall_c0_d     = stall_next(stall_c0_q, c0_blocked, stats_clr);
    stall_c1_d     = stall_next(stall_c1_q, c1_blocked, stats_clr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      beats_left_q   <= 2'd0;
      err_pkt_q      <= 1'b0;
      stall_c0_q     <= '0;
      stall_c1_q     <= '0;
      fiu_c0_valid_q <= 1'b0;
      fiu_c1_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      beats_left_q   <= beats_left_d;
      err_pkt_q      <= err_pkt_d;
      stall_c0_q     <= stall_c0_d;
      stall_c1_q     <= stall_c1_d;
      fiu_c0_valid_q <= fiu_c0_valid_d;
      fiu_c1_valid_q <= fiu_c1_valid_d;
    end
  end

  // Payload registers need no reset; they are qualified by the valids.
  always_ff @(posedge clk) begin
    if (deq) begin
      fiu_c0_data_q <= head_c0_data;
      fiu_c1_data_q <= head_c1_data;
    end
  end

  assign deq_tx       = deq;
  assign fiu_c0_valid = fiu_c0_valid_q;
  assign fiu_c0_data  = fiu_c0_data_q;
  assign fiu_c1_valid = fiu_c1_valid_q;
  assign fiu_c1_data  = fiu_c1_data_q;
  assign stall_c0     = stall_c0_q;
  assign stall_c1     = stall_c1_q;
  assign err_pkt      = err_pkt_q;

endmodule

// File: tb/tb_cci_mpf_shim_lockstep_issue.sv
// Self-checking bench for cci_mpf_shim_lockstep_issue: directed scenarios plus
// randomized heads, checked against a transaction-level reference model.
module tb_cci_mpf_shim_lockstep_issue;

  localparam int C0B = 100;
  localparam int C1B = 600;
  localparam int SB  = 16;
  localparam int SAT = 65535;

  logic           clk = 1'b0;
  logic           reset;
  logic           hne, c0v, c1v, wr, sop;
  logic [1:0]     len;
  logic [C0B-1:0] d0;
  logic [C1B-1:0] d1;
  logic           af0, af1, clr;
  logic           deq_tx;
  logic           fiu_c0_valid, fiu_c1_valid;
  logic [C0B-1:0] fiu_c0_data;
  logic [C1B-1:0] fiu_c1_data;
  logic [SB-1:0]  stall_c0, stall_c1;
  logic           err_pkt;

  int errors = 0;
  int checks = 0;

  // Reference model state: remaining beats of the open packet, expected outputs.
  int             m_rem;
  bit             m_err;
  int             m_s0, m_s1;
  bit             m_v0, m_v1;
  logic [C0B-1:0] m_d0;
  logic [C1B-1:0] m_d1;
  bit             m_last_deq;

  cci_mpf_shim_lockstep_issue #(
    .C0_TX_BITS(C0B), .C1_TX_BITS(C1B), .STAT_BITS(SB)
  ) dut (
    .clk(clk), .reset(reset),
    .head_not_empty(hne), .head_c0_valid(c0v), .head_c0_data(d0),
    .head_c1_valid(c1v), .head_c1_is_wr(wr), .head_c1_sop(sop),
    .head_c1_len(len), .head_c1_data(d1), .deq_tx(deq_tx),
    .fiu_c0_almfull(af0), .fiu_c1_almfull(af1),
    .fiu_c0_valid(fiu_c0_valid), .fiu_c0_data(fiu_c0_data),
    .fiu_c1_valid(fiu_c1_valid), .fiu_c1_data(fiu_c1_data),
    .stats_clr(clr), .stall_c0(stall_c0), .stall_c1(stall_c1),
    .err_pkt(err_pkt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [C1B-1:0] got, input logic [C1B-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [C1B-1:0] rnd_bits();
    logic [C1B-1:0] r;
    r = '0;
    for (int i = 0; i < 19; i++) r = {r[C1B-33:0], $urandom()};
    return r;
  endfunction

  task automatic model_reset();
    m_rem = 0; m_err = 0; m_s0 = 0; m_s1 = 0; m_v0 = 0; m_v1 = 0; m_last_deq = 0;
  endtask

  task automatic set_head(input bit n, input bit v0, input bit v1, input bit w,
                          input bit s, input logic [1:0] l);
    hne = n; c0v = v0; c1v = v1; wr = w; sop = s; len = l;
    d0 = rnd_bits(); d1 = rnd_bits();
  endtask

  // One clock: check the combinational dequeue, advance the model, check outputs.
  task automatic cycle();
    bit exp_deq;
    @(negedge clk);
    exp_deq = hne && !(c0v && af0) && !(c1v && af1 && (m_rem == 0));
    chk("deq_tx", deq_tx, exp_deq);
    @(posedge clk);
    if (clr) m_s0 = 0; else if (hne && c0v && af0 && m_s0 < SAT) m_s0++;
    if (clr) m_s1 = 0; else if (hne && c1v && af1 && m_rem == 0 && m_s1 < SAT) m_s1++;
    m_v0 = exp_deq && c0v;
    m_v1 = exp_deq && c1v;
    if (exp_deq) begin m_d0 = d0; m_d1 = d1; end
    if (exp_deq && c1v && wr) begin
      if (sop) begin
        if (m_rem != 0) m_err = 1;
        m_rem = int'(len);
      end else if (m_rem == 0) m_err = 1;
      else m_rem--;
    end
    m_last_deq = exp_deq;
    #1;
    chk("fiu_c0_valid", fiu_c0_valid, m_v0);
    chk("fiu_c1_valid", fiu_c1_valid, m_v1);
    if (m_v0) chk("fiu_c0_data", fiu_c0_data, m_d0);
    if (m_v1) chk("fiu_c1_data", fiu_c1_data, m_d1);
    chk("stall_c0", stall_c0, m_s0[SB-1:0]);
    chk("stall_c1", stall_c1, m_s1[SB-1:0]);
    chk("err_pkt", err_pkt, m_err);
  endtask

  initial begin
    reset = 1; clr = 0; af0 = 0; af1 = 0;
    set_head(1, 1, 1, 1, 1, 2'd0);
    model_reset();
    #1;
    chk("rst_deq", deq_tx, 1'b0);
    chk("rst_v0", fiu_c0_valid, 1'b0);
    chk("rst_v1", fiu_c1_valid, 1'b0);
    chk("rst_s0", stall_c0, 0);
    chk("rst_s1", stall_c1, 0);
    chk("rst_err", err_pkt, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 0;
    @(posedge clk); #1;

    // 1) c0 read + c1 single-beat write, no back-pressure
    set_head(1, 1, 1, 1, 1, 2'd0);
    cycle();
    chk("t1_d0", fiu_c0_data, d0);
    chk("t1_d1", fiu_c1_data, d1);
    $display("t1 single issue done");

    // 2) c0 almfull for 5 cycles blocks the whole entry
    clr = 1; set_head(0, 0, 0, 0, 0, 2'd0); cycle(); clr = 0;
    set_head(1, 1, 1, 0, 0, 2'd0); af0 = 1;
    repeat (5) cycle();
    chk("t2_s0", stall_c0, 5);
    chk("t2_s1", stall_c1, 0);
    af0 = 0; cycle();
    set_head(0, 0, 0, 0, 0, 2'd0); cycle();
    $display("t2 c0 stall done");

    // 3) 4-beat write with c1 almfull rising after the first beat
    set_head(1, 0, 1, 1, 1, 2'd3); cycle();
    af1 = 1;
    for (int b = 0; b < 3; b++) begin set_head(1, 0, 1, 1, 0, 2'd0); cycle(); end
    chk("t3_err", err_pkt, 1'b0);
    chk("t3_s1", stall_c1, 0);
    set_head(1, 0, 1, 1, 1, 2'd0); cycle();
    chk("t3_idle_stall", stall_c1, 1);
    af1 = 0; cycle();
    $display("t3 multi-beat done");

    // 4) SOP arriving mid-packet
    set_head(1, 0, 1, 1, 1, 2'd3); cycle();
    set_head(1, 0, 1, 1, 0, 2'd0); cycle();
    set_head(1, 1, 1, 1, 1, 2'd1); cycle();
    chk("t4_err", err_pkt, 1'b1);
    set_head(1, 0, 1, 1, 0, 2'd0); cycle();
    af1 = 1; set_head(1, 0, 1, 1, 1, 2'd0); cycle();
    chk("t4_reload_idle", deq_tx, 1'b0);
    af1 = 0; cycle();
    $display("t4 framing error done");

    // Randomized heads; a head is replaced only once it has been dequeued.
    for (int i = 0; i < 400; i++) begin
      if (m_last_deq || !hne || i == 0) begin
        set_head($urandom_range(7) != 0, $urandom_range(1), $urandom_range(1),
                 $urandom_range(3) != 0,
                 (m_rem != 0) ? ($urandom_range(7) == 0) : ($urandom_range(7) != 0),
                 2'($urandom_range(3)));
      end
      af0 = ($urandom_range(3) == 0);
      af1 = ($urandom_range(3) == 0);
      clr = ($urandom_range(31) == 0);
      cycle();
    end
    clr = 0; af0 = 0; af1 = 0;
    set_head(1, 0, 1, 1, 1, 2'd0); cycle();
    $display("random phase done");

    // 5) stall_c1 saturation and clear
    clr = 1; set_head(0, 0, 0, 0, 0, 2'd0); cycle(); clr = 0;
    set_head(1, 0, 1, 0, 0, 2'd0); af1 = 1;
    repeat (SAT - 1) cycle();
    chk("t5_fffe", stall_c1, 16'hFFFE);
    repeat (3) cycle();
    chk("t5_sat", stall_c1, 16'hFFFF);
    clr = 1; cycle(); clr = 0;
    chk("t5_clr", stall_c1, 0);
    af1 = 0; set_head(0, 0, 0, 0, 0, 2'd0); cycle();
    $display("t5 saturation done");

    // 6) async reset in the middle of a packet
    set_head(1, 1, 1, 1, 1, 2'd3); cycle();
    set_head(1, 1, 1, 1, 0, 2'd0); cycle();
    chk("t6_pre_v1", fiu_c1_valid, 1'b1);
    reset = 1; #1;
    model_reset();
    chk("t6_deq", deq_tx, 1'b0);
    chk("t6_v0", fiu_c0_valid, 1'b0);
    chk("t6_v1", fiu_c1_valid, 1'b0);
    chk("t6_err", err_pkt, 1'b0);
    chk("t6_s0", stall_c0, 0);
    set_head(0, 0, 0, 0, 0, 2'd0);
    @(negedge clk) reset = 0;
    @(posedge clk); #1;
    set_head(1, 0, 1, 1, 1, 2'd1); cycle();
    set_head(1, 0, 1, 1, 0, 2'd0); cycle();
    chk("t6_clean", err_pkt, 1'b0);
    set_head(0, 0, 0, 0, 0, 2'd0); cycle();
    $display("t6 reset mid-packet done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
